// File: rtl/discrete_decimating_sink.sv
// discrete_decimating_sink: box-car decimator feeding a FWFT valid/ready FIFO; MISTER_DISCRETE_SIGNED_OUT_EN flips out_data to two's complement
module discrete_decimating_sink #(
  parameter int DECIM = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        I_RST,
  input  logic        audio_clk_en,
  input  logic [15:0] in,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic [4:0]  fill
);
  localparam int SH = $clog2(DECIM);
  localparam int AW = 16 + SH;
  localparam int CW = SH > 0 ? SH : 1;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  logic [AW-1:0] acc, sum;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wr, rd;
  logic [15:0] mem [FIFO_DEPTH];
  logic [15:0] avg, head;
  logic last, push, pop, full, acc_push, drop;
  always_comb begin
    sum = acc + AW'(in);
    avg = sum[SH +: 16];
    last = cnt == CW'(DECIM - 1);
    push = audio_clk_en && last;
    full = fill == 5'(FIFO_DEPTH);
    pop = out_valid && out_ready;
    acc_push = push && (!full || pop);
    drop = push && full && !pop;
    head = mem[rd];
  end
  assign out_valid = fill != 5'd0;
`ifdef MISTER_DISCRETE_SIGNED_OUT_EN
  assign out_data = out_valid ? head ^ 16'h8000 : 16'h0000;
`else
  assign out_data = out_valid ? head : 16'h0000;
`endif
  always_ff @(posedge clk) begin
    if (I_RST) begin
      acc <= '0;
      cnt <= '0;
      wr <= '0;
      rd <= '0;
      fill <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      if (audio_clk_en) begin
        acc <= last ? '0 : sum;
        cnt <= last ? '0 : cnt + CW'(1);
      end
      if (acc_push) begin
        mem[wr] <= avg;
        wr <= wr + PW'(1);
      end
      if (pop) rd <= rd + PW'(1);
      fill <= fill + 5'(acc_push) - 5'(pop);
      overflow <= drop;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_discrete_decimating_sink.sv
// tb_discrete_decimating_sink: directed vectors for DECIM=4 and DECIM=1 instances
module tb_discrete_decimating_sink;
  logic clk = 0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic rst4, en4, rdy4, v4, o4, rst1, en1, rdy1, v1, o1;
  logic [15:0] d4, q4, d1, q1;
  logic [7:0] dc4, dc1;
  logic [4:0] f4, f1;
  discrete_decimating_sink #(.DECIM(4), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .I_RST(rst4), .audio_clk_en(en4), .in(d4), .out_data(q4), .out_valid(v4),
    .out_ready(rdy4), .overflow(o4), .drop_count(dc4), .fill(f4));
  discrete_decimating_sink #(.DECIM(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .I_RST(rst1), .audio_clk_en(en1), .in(d1), .out_data(q1), .out_valid(v1),
    .out_ready(rdy1), .overflow(o1), .drop_count(dc1), .fill(f1));
  function automatic logic [15:0] sx(input logic [15:0] v);
`ifdef MISTER_DISCRETE_SIGNED_OUT_EN
    return v ^ 16'h8000;
`else
    return v;
`endif
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic en; logic [15:0] d; logic rdy;
    logic v; logic [15:0] q; logic [4:0] f; logic o; logic [7:0] dc;
  } vec_t;
  vec_t tv[17];
  initial begin
    tv[0]  = '{1'b1, 16'd1, 1'b0, 1'b1, sx(16'd1), 5'd1, 1'b0, 8'd0};
    tv[1]  = '{1'b1, 16'd2, 1'b0, 1'b1, sx(16'd1), 5'd2, 1'b0, 8'd0};
    tv[2]  = '{1'b1, 16'd3, 1'b0, 1'b1, sx(16'd1), 5'd3, 1'b0, 8'd0};
    tv[3]  = '{1'b1, 16'd4, 1'b0, 1'b1, sx(16'd1), 5'd4, 1'b0, 8'd0};
    tv[4]  = '{1'b1, 16'd5, 1'b0, 1'b1, sx(16'd1), 5'd4, 1'b1, 8'd1};
    tv[5]  = '{1'b1, 16'd6, 1'b0, 1'b1, sx(16'd1), 5'd4, 1'b1, 8'd2};
    tv[6]  = '{1'b0, 16'd0, 1'b0, 1'b1, sx(16'd1), 5'd4, 1'b0, 8'd2};
    tv[7]  = '{1'b1, 16'd9, 1'b1, 1'b1, sx(16'd2), 5'd4, 1'b0, 8'd2};
    tv[8]  = '{1'b0, 16'd0, 1'b1, 1'b1, sx(16'd3), 5'd3, 1'b0, 8'd2};
    tv[9]  = '{1'b0, 16'd0, 1'b1, 1'b1, sx(16'd4), 5'd2, 1'b0, 8'd2};
    tv[10] = '{1'b0, 16'd0, 1'b1, 1'b1, sx(16'd9), 5'd1, 1'b0, 8'd2};
    tv[11] = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 5'd0, 1'b0, 8'd2};
    tv[12] = '{1'b1, 16'd7, 1'b1, 1'b1, sx(16'd7), 5'd1, 1'b0, 8'd2};
    tv[13] = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 5'd0, 1'b0, 8'd2};
    tv[14] = '{1'b1, 16'h8000, 1'b0, 1'b1, sx(16'h8000), 5'd1, 1'b0, 8'd2};
    tv[15] = '{1'b1, 16'hFFFF, 1'b1, 1'b1, sx(16'hFFFF), 5'd1, 1'b0, 8'd2};
    tv[16] = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 5'd0, 1'b0, 8'd2};
    {rst4, en4, rdy4, d4, rst1, en1, rdy1, d1} = '0;
    rst4 = 1; rst1 = 1;
    step; step;
    rst4 = 0; rst1 = 0;
    chk("rst_valid4", v4, 0); chk("rst_data4", q4, 0); chk("rst_fill4", f4, 0);
    chk("rst_ovf4", o4, 0); chk("rst_drop4", dc4, 0);
    chk("rst_valid1", v1, 0); chk("rst_fill1", f1, 0); chk("rst_drop1", dc1, 0);
    // DECIM=4 averaging with idle cycles between strobes
    rdy4 = 1;
    foreach (tv[i]) begin end
    for (int i = 0; i < 4; i++) begin
      en4 = 1; d4 = (i == 0) ? 16'd100 : (i == 1) ? 16'd200 : (i == 2) ? 16'd300 : 16'd401;
      step;
      en4 = 0;
      if (i < 3) chk("avg_premature_valid", v4, 0);
      else begin
        chk("avg_valid", v4, 1); chk("avg_data", q4, sx(16'd250)); chk("avg_fill", f4, 1);
      end
      if (i < 3) step;
    end
    step;
    chk("avg_popped", v4, 0); chk("avg_popped_fill", f4, 0);
    // partial group discarded by reset
    for (int i = 0; i < 2; i++) begin en4 = 1; d4 = 16'd1000; step; end
    en4 = 0; rst4 = 1; step; rst4 = 0;
    chk("midrst_fill", f4, 0); chk("midrst_valid", v4, 0);
    for (int i = 0; i < 4; i++) begin en4 = 1; d4 = 16'd8; step; end
    en4 = 0; rdy4 = 0;
    chk("midrst_valid_after", v4, 1); chk("midrst_data", q4, sx(16'd8)); chk("midrst_fill_after", f4, 1);
    // DECIM=1 table
    for (int i = 0; i < 17; i++) begin
      en1 = tv[i].en; d1 = tv[i].d; rdy1 = tv[i].rdy;
      step;
      chk($sformatf("tv%0d_valid", i), v1, tv[i].v);
      chk($sformatf("tv%0d_data", i), q1, tv[i].q);
      chk($sformatf("tv%0d_fill", i), f1, tv[i].f);
      chk($sformatf("tv%0d_ovf", i), o1, tv[i].o);
      chk($sformatf("tv%0d_drop", i), dc1, tv[i].dc);
    end
    // drop_count saturation
    rdy1 = 0;
    for (int i = 0; i < 4; i++) begin en1 = 1; d1 = 16'(i); step; end
    chk("sat_full", f1, 4);
    for (int k = 1; k <= 300; k++) begin
      en1 = 1; d1 = 16'hABCD; step;
      chk("sat_drop", dc1, (k + 2 > 255) ? 255 : k + 2);
    end
    chk("sat_ovf_held", o1, 1);
    en1 = 0; step;
    chk("sat_ovf_end", o1, 0); chk("sat_final", dc1, 255); chk("sat_head", q1, sx(16'd0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
